psg_audio_dac: RTL and testbench

PSG_AUDIO_DAC -- requirements
Module: psg_audio_dac

---
 rtl/psg_audio_dac.sv | 101 ++++++++++
 tb/tb_psg_audio_dac.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/psg_audio_dac.sv
// PSG audio back end: box-car decimator, first-order DC blocker, volume/mute
// scaling and a first-order sigma-delta bitstream for the board audio pin.
module psg_audio_dac #(
    parameter int DECIM = 4,
    parameter int DCK   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [13:0] mix,
    input  logic [1:0]  vol,
    input  logic        mute,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        dac_out
);

    localparam int ACC_W = 14 + DECIM;
    localparam int DC_W  = 14 + DCK;
    // Mid-scale of the 0..12285 mix range, so the first samples do not thump.
    localparam logic [DC_W-1:0] DC_INIT = {14'd6142, {DCK{1'b0}}};

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [DECIM-1:0]  cnt;
    logic              v1;
    logic [13:0]       avg;

    logic [DC_W-1:0]   dc_est;
    logic [13:0]       dc_int;
    logic signed [14:0]   diff;
    logic signed [DC_W:0] dc_err;
    logic signed [DC_W:0] dc_step;
    logic signed [DC_W:0] dc_next;
    logic signed [15:0]   scaled;

    logic [15:0]       sd_acc;
    logic [16:0]       sd_sum;

    assign acc_sum = acc + ACC_W'(mix);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
            v1  <= 1'b0;
            avg <= '0;
        end else begin
            v1 <= 1'b0;
            if (ce) begin
                if (cnt == '1) begin
                    avg <= acc_sum[ACC_W-1:DECIM];
                    acc <= '0;
                    cnt <= '0;
                    v1  <= 1'b1;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + DECIM'(1);
                end
            end
        end
    end

    // Leaky integrator: dc_est moves 1/2^DCK of the way toward avg per sample.
    assign dc_int  = dc_est[DC_W-1:DCK];
    assign diff    = $signed({1'b0, avg}) - $signed({1'b0, dc_int});
    assign dc_err  = $signed({1'b0, avg, {DCK{1'b0}}}) - $signed({1'b0, dc_est});
    assign dc_step = dc_err >>> DCK;
    assign dc_next = $signed({1'b0, dc_est}) + dc_step;
    assign scaled  = $signed({diff, 1'b0}) >>> vol;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dc_est       <= DC_INIT;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= v1;
            if (v1) begin
                dc_est <= DC_W'(dc_next);
                sample <= mute ? 16'd0 : scaled;
            end
        end
    end

    // Offset-binary view of the signed sample: adding 32768 flips the MSB.
    assign sd_sum = {1'b0, sd_acc} + {1'b0, sample ^ 16'h8000};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sd_acc  <= '0;
            dac_out <= 1'b0;
        end else begin
            sd_acc  <= sd_sum[15:0];
            dac_out <= sd_sum[16];
        end
    end

endmodule

// File: tb/tb_psg_audio_dac.sv
// Self-checking bench for psg_audio_dac: directed scenarios plus random traffic,
// every clock compared against a block-level arithmetic model of the audio path.
module tb_psg_audio_dac;

    localparam int DECIM = 4;
    localparam int DCK   = 8;
    localparam int N     = 1 << DECIM;

    logic        clock;
    logic        reset;
    logic        ce;
    logic [13:0] mix;
    logic [1:0]  vol;
    logic        mute;
    logic [15:0] sample;
    logic        sample_valid;
    logic        dac_out;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_seen = 0;

    // Reference model state, in plain integers.
    int     q_sum, q_cnt;
    bit     pend;
    int     pend_avg;
    longint m_dc;
    int     m_sample;
    int     m_valid;
    int     m_sd;
    int     m_dac;

    psg_audio_dac #(.DECIM(DECIM), .DCK(DCK)) dut (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .mix         (mix),
        .vol         (vol),
        .mute        (mute),
        .sample      (sample),
        .sample_valid(sample_valid),
        .dac_out     (dac_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_sum = 0; q_cnt = 0; pend = 0; pend_avg = 0;
        m_dc = longint'(6142) * (1 << DCK);
        m_sample = 0; m_valid = 0; m_sd = 0; m_dac = 0;
    endtask

    // One clock edge of the model, using the inputs presented at that edge.
    task automatic model_edge();
        int s, d;
        s = m_sd + m_sample + 32768;
        m_dac = (s >= 65536) ? 1 : 0;
        m_sd  = s % 65536;
        if (pend) begin
            d = pend_avg - int'(m_dc / (1 << DCK));
            m_sample = mute ? 0 : int'(fdiv(2 * d, 1 << vol));
            m_dc = m_dc + fdiv(longint'(pend_avg) * (1 << DCK) - m_dc, 1 << DCK);
            m_valid = 1;
            pend = 0;
        end else begin
            m_valid = 0;
        end
        if (ce) begin
            q_sum += int'(mix);
            q_cnt++;
            if (q_cnt == N) begin
                pend = 1;
                pend_avg = q_sum / N;
                q_sum = 0;
                q_cnt = 0;
            end
        end
    endtask

    task automatic step(input bit c, input int m);
        ce  = c;
        mix = 14'(m);
        @(posedge clock);
        model_edge();
        #1;
        chk("sample", $signed(sample), m_sample);
        chk("sample_valid", sample_valid, m_valid);
        chk("dac_out", dac_out, m_dac);
        if (sample_valid === 1'b1) valid_seen++;
    endtask

    task automatic block(input int m);
        repeat (N) step(1'b1, m);
        step(1'b0, m);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_sample", $signed(sample), 0);
        chk("rst_async_valid", sample_valid, 0);
        chk("rst_async_dac", dac_out, 0);
        model_reset();
        @(posedge clock);
        #1;
        chk("rst_hold_sample", $signed(sample), 0);
        reset = 1'b0;
    endtask

    initial begin
        int prev;
        reset = 1'b1; ce = 1'b0; mix = '0; vol = '0; mute = 1'b0;
        model_reset();
        #1;
        chk("init_sample", $signed(sample), 0);
        chk("init_valid", sample_valid, 0);
        chk("init_dac", dac_out, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Mid-scale constant input: DC-free, so sample stays 0 and dac_out is 50%.
        repeat (N) step(1'b1, 6142);
        chk("mid_valid_v1_edge", sample_valid, 0);
        step(1'b0, 6142);
        chk("mid_valid", sample_valid, 1);
        chk("mid_sample", $signed(sample), 0);
        step(1'b0, 6142);
        chk("mid_valid_pulse", sample_valid, 0);
        repeat (4) step(1'b0, 6142);

        // Full-scale step from reset, then monotonic decay.
        do_reset();
        block(12285);
        chk("step_first", $signed(sample), 12286);
        block(12285);
        chk("step_second", $signed(sample), 12240);
        prev = 12240;
        repeat (4) begin
            block(12285);
            chk("step_decay", ($signed(sample) < prev && $signed(sample) > 0) ? 1 : 0, 1);
            prev = int'($signed(sample));
        end

        // Attenuation, then mute with the DC tracker still running.
        do_reset();
        vol = 2'd2;
        block(12285);
        chk("vol2_first", $signed(sample), 3071);
        do_reset();
        vol = 2'd0; mute = 1'b1;
        block(12285);
        chk("mute_first", $signed(sample), 0);
        mute = 1'b0;
        block(12285);
        chk("unmute_second", $signed(sample), 12240);

        // Reset mid-block discards the partial sum.
        do_reset();
        repeat (7) step(1'b1, $urandom_range(0, 12285));
        do_reset();
        valid_seen = 0;
        repeat (N - 1) step(1'b1, $urandom_range(0, 12285));
        repeat (2) step(1'b0, 0);
        chk("partial_no_valid", valid_seen, 0);
        step(1'b1, $urandom_range(0, 12285));
        step(1'b0, 0);
        chk("partial_full_valid", sample_valid, 1);

        // Long ce gap mid-block freezes the decimator.
        repeat (8) step(1'b1, $urandom_range(0, 12285));
        valid_seen = 0;
        repeat (100) step(1'b0, $urandom_range(0, 12285));
        chk("gap_no_valid", valid_seen, 0);
        repeat (8) step(1'b1, $urandom_range(0, 12285));
        step(1'b0, 0);
        chk("gap_valid", sample_valid, 1);

        // Random traffic with occasional async resets.
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) vol = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mute = ~mute;
            if ($urandom_range(0, 599) == 0) do_reset();
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 12285));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
